// File: rtl/fp16_pkg.sv
// Shared types and constants for the binary16 add sequencer.
// Holds the FSM state encoding and the unpacked-operand record latched at accept.
package fp16_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS  = 15;

  localparam logic [15:0] QNAN = 16'h7E00;
  localparam logic [15:0] PINF = 16'h7C00;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   mant;
    logic             is_zero;
    logic             is_inf;
    logic             is_nan;
  } op_t;

  // Subnormals (exp==0) are flushed to zero; exp==31 marks inf/NaN.
  function automatic op_t unpack(input logic [15:0] x);
    op_t o;
    o.sign    = x[15];
    o.exp     = x[14:10];
    o.is_zero = (x[14:10] == '0);
    o.is_inf  = (x[14:10] == '1) && (x[9:0] == '0);
    o.is_nan  = (x[14:10] == '1) && (x[9:0] != '0);
    o.mant    = o.is_zero ? '0 : {1'b1, x[9:0]};
    return o;
  endfunction

endpackage

// File: rtl/fp16_norm_detect.sv
// Priority encoder turning the 12-bit mantissa sum into a normalization shift.
// dir=1 means one right shift (carry out); otherwise shamt is the left shift to bit 10.
module fp16_norm_detect
  import fp16_pkg::*;
(
  input  logic [MAN_W+1:0] sum,
  output logic             dir,
  output logic [3:0]       shamt,
  output logic             zero
);

  always_comb begin
    dir   = sum[MAN_W+1];
    zero  = (sum == '0);
    shamt = 4'd0;
    if (sum[MAN_W+1]) begin
      shamt = 4'd1;
    end else begin
      // Ascending scan: the highest set bit writes last and wins.
      for (int i = 0; i <= MAN_W; i++) begin
        if (sum[i]) shamt = 4'(MAN_W - i);
      end
    end
  end

endmodule

// File: rtl/fp16_add_seq.sv
// Multi-cycle binary16 adder: accept, ALIGN, ADD, NORM, DONE, one state per cycle.
// Truncating, flush-to-zero; one operation in flight, result held until out_ready.
module fp16_add_seq
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        busy
);

  state_t state, state_nxt;

  op_t              op_a, op_b;
  logic [15:0]      raw_a, raw_b;
  logic             sign_r, sub_r;
  logic [EXP_W-1:0] exp_r;
  logic [MAN_W:0]   m_l, m_s;
  logic [MAN_W+1:0] sum_r;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = ALIGN;
      ALIGN:   state_nxt = ADD;
      ADD:     state_nxt = NORM;
      NORM:    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  // Alignment: larger magnitude by {exp, frac}; ties keep A as the larger.
  logic             a_ge;
  op_t              op_l, op_s;
  logic [EXP_W-1:0] d;
  logic [MAN_W:0]   m_s_sh;

  always_comb begin
    a_ge   = {op_a.exp, op_a.mant[MAN_W-1:0]} >= {op_b.exp, op_b.mant[MAN_W-1:0]};
    op_l   = a_ge ? op_a : op_b;
    op_s   = a_ge ? op_b : op_a;
    d      = op_l.exp - op_s.exp;
    m_s_sh = (d >= EXP_W'(MAN_W + 2)) ? '0 : (op_s.mant >> d);
  end

  logic                   n_dir, n_zero;
  logic [3:0]             n_shamt;
  logic [MAN_W+1:0]       sum_shl;
  logic [MAN_W:0]         mant_n;
  logic signed [EXP_W+1:0] exp_n;
  logic [15:0]            norm_res, spec_res;
  logic                   spec_hit;

  fp16_norm_detect u_norm (
    .sum   (sum_r),
    .dir   (n_dir),
    .shamt (n_shamt),
    .zero  (n_zero)
  );

  always_comb begin
    sum_shl = sum_r << n_shamt;
    mant_n  = n_dir ? sum_r[MAN_W+1:1] : sum_shl[MAN_W:0];
    exp_n   = n_dir ? $signed({2'b00, exp_r}) + 7'sd1
                    : $signed({2'b00, exp_r}) - $signed({3'b000, n_shamt});
    if (n_zero)             norm_res = 16'h0000;
    else if (exp_n >= 7'sd31) norm_res = {sign_r, PINF[14:0]};
    else if (exp_n <= 7'sd0)  norm_res = {sign_r, 15'h0000};
    else                    norm_res = {sign_r, exp_n[EXP_W-1:0], mant_n[MAN_W-1:0]};

    spec_hit = 1'b1;
    spec_res = QNAN;
    if (op_a.is_nan || op_b.is_nan)                               spec_res = QNAN;
    else if (op_a.is_inf && op_b.is_inf && op_a.sign != op_b.sign) spec_res = QNAN;
    else if (op_a.is_inf)                                         spec_res = {op_a.sign, PINF[14:0]};
    else if (op_b.is_inf)                                         spec_res = {op_b.sign, PINF[14:0]};
    else if (op_a.is_zero && op_b.is_zero)                        spec_res = {op_a.sign & op_b.sign, 15'h0000};
    else if (op_a.is_zero)                                        spec_res = raw_b;
    else if (op_b.is_zero)                                        spec_res = raw_a;
    else                                                          spec_hit = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      raw_a  <= '0;
      raw_b  <= '0;
      sign_r <= 1'b0;
      sub_r  <= 1'b0;
      exp_r  <= '0;
      m_l    <= '0;
      m_s    <= '0;
      sum_r  <= '0;
      result <= 16'h0000;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_a  <= unpack(a);
          op_b  <= unpack(b);
          raw_a <= a;
          raw_b <= b;
        end
        ALIGN: begin
          sign_r <= op_l.sign;
          sub_r  <= op_l.sign ^ op_s.sign;
          exp_r  <= op_l.exp;
          m_l    <= op_l.mant;
          m_s    <= m_s_sh;
        end
        ADD:  sum_r  <= sub_r ? ({1'b0, m_l} - {1'b0, m_s}) : ({1'b0, m_l} + {1'b0, m_s});
        NORM: result <= spec_hit ? spec_res : norm_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_add_seq.sv
// Directed plus random bench for fp16_add_seq against an integer reference of the add rules.
module tb_fp16_add_seq;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] a, b, result;

  int errors = 0;
  int checks = 0;

  fp16_add_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: aligned integer add then normalize by repeated shifting.
  function automatic logic [15:0] ref_add(input logic [15:0] x, input logic [15:0] y);
    int ex, ey, fx, fy, mx, my, el, es, ml, ms, d, mag, e;
    logic sx, sy, sl, ss, zx, zy, ix, iy, nx, ny, x_big;
    sx = x[15]; ex = int'(x[14:10]); fx = int'(x[9:0]);
    sy = y[15]; ey = int'(y[14:10]); fy = int'(y[9:0]);
    zx = (ex == 0); zy = (ey == 0);
    ix = (ex == 31) && (fx == 0); iy = (ey == 31) && (fy == 0);
    nx = (ex == 31) && (fx != 0); ny = (ey == 31) && (fy != 0);
    if (nx || ny) return 16'h7E00;
    if (ix && iy && sx != sy) return 16'h7E00;
    if (ix) return {sx, 15'h7C00};
    if (iy) return {sy, 15'h7C00};
    if (zx && zy) return {sx & sy, 15'h0};
    if (zx) return y;
    if (zy) return x;
    mx = 1024 + fx; my = 1024 + fy;
    x_big = (ex > ey) || (ex == ey && fx >= fy);
    if (x_big) begin sl = sx; ss = sy; el = ex; es = ey; ml = mx; ms = my; end
    else       begin sl = sy; ss = sx; el = ey; es = ex; ml = my; ms = mx; end
    d   = el - es;
    ms  = (d >= 12) ? 0 : (ms / (1 << d));
    mag = (sl == ss) ? ml + ms : ml - ms;
    if (mag == 0) return 16'h0000;
    e = el;
    while (mag >= 2048) begin mag = mag / 2; e++; end
    while (mag < 1024)  begin mag = mag * 2; e--; end
    if (e >= 31) return {sl, 15'h7C00};
    if (e <= 0)  return {sl, 15'h0};
    return {sl, e[4:0], mag[9:0]};
  endfunction

  // Issue one operation, check latency/status/result, optionally stall in DONE.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input string tag,
                        input int hold);
    int n;
    logic [15:0] exp_res, held;
    exp_res = ref_add(x, y);
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    in_valid = 1'b1; a = x; b = y;
    tick();
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      check({tag, " busy"}, {14'd0, busy, in_ready}, 16'b10);
      tick();
      n++;
    end
    check({tag, " latency"}, 16'(n), 16'd3);
    check(tag, result, exp_res);
    held = result;
    for (int i = 0; i < hold; i++) begin
      in_valid = (i == 0); a = 16'h3C00; b = 16'h3C00;
      tick();
      in_valid = 1'b0;
      check({tag, " stall"}, {13'd0, out_valid, in_ready, busy}, 16'b101);
      check({tag, " held"}, result, held);
    end
    out_ready = 1'b1;
    tick();
    check({tag, " back to idle"}, {14'd0, in_ready, out_valid}, 16'b10);
  endtask

  initial begin
    int bad;
    logic [15:0] x, y;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset status", {13'd0, in_ready, out_valid, busy}, 16'b100);
    check("reset result", result, 16'h0000);

    run_op(16'h3C00, 16'h3C00, "1+1", 0);
    check("1+1 model", ref_add(16'h3C00, 16'h3C00), 16'h4000);
    run_op(16'h3C00, 16'hBC00, "cancel", 0);
    run_op(16'h4200, 16'hC000, "left norm", 0);
    run_op(16'h6400, 16'h3C00, "align d10", 0);
    run_op(16'h6400, 16'h3800, "align d11", 0);
    run_op(16'h6400, 16'h0001, "subnormal flush", 0);
    run_op(16'h7BFF, 16'h7BFF, "overflow", 0);
    run_op(16'h7C00, 16'h3C00, "inf+fin", 0);
    run_op(16'h7C00, 16'hFC00, "inf-inf", 0);
    run_op(16'h7E01, 16'h0000, "nan", 0);
    run_op(16'h8000, 16'h8000, "-0+-0", 0);
    run_op(16'h0400, 16'h8401, "underflow", 0);

    // Stall in DONE with a stray in_valid pulse that must be ignored.
    out_ready = 1'b0;
    run_op(16'h4200, 16'h3C00, "backpressure", 3);
    run_op(16'h6400, 16'h3C00, "after stall", 0);

    // Abort during ADD.
    in_valid = 1'b1; a = 16'h3C00; b = 16'h4000;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort status", {13'd0, in_ready, out_valid, busy}, 16'b100);
    check("abort result", result, 16'h0000);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid !== 1'b0) bad++;
      tick();
    end
    check("abort no output", 16'(bad), 16'd0);
    run_op(16'h4000, 16'h4000, "after abort", 0);

    for (int i = 0; i < 150; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      if ($urandom_range(0, 2) != 0) y[14:10] = x[14:10] ^ 5'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) x[14:10] = 5'h1F;
      if ($urandom_range(0, 15) == 0) y[14:10] = 5'h00;
      run_op(x, y, $sformatf("rand%0d %h+%h", i, x, y), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp16_add_seq.md
Name: fp16_add_seq

Overview:
- Multi-cycle sequencer for the half-precision floating-point adder.
- Accepts an operand pair over a valid/ready handshake and steps it through ALIGN, ADD, NORM and DONE, one state per cycle.
- Drives the normalization detector to turn the 12-bit mantissa sum into a shift direction and amount.
- Sits between the operand source (register file or issue logic) and the result consumer. Fixed latency; one operation in flight.

Parameters:
- EXP_W, 5, exponent width
- MAN_W, 10, stored fraction width; the internal sum is MAN_W+2 = 12 bits
- BIAS, 15, exponent bias

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  high only in IDLE
- a  in  16  operand A, IEEE binary16
- b  in  16  operand B, IEEE binary16
- out_valid  out  1  result valid (DONE state)
- out_ready  in  1  consumer accepts result
- result  out  16  binary16 sum, held stable while out_valid=1
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset are decided: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, result=16'h0000, all internal registers cleared. Reset wins over every other event. rst asserted in any state returns to IDLE on the next edge and discards the in-flight operation. No result is emitted.
- FSM: IDLE -> ALIGN -> ADD -> NORM -> DONE -> IDLE.
- IDLE: on in_valid&&in_ready, latch a and b, go to ALIGN. Otherwise stay.
- Latency: accept at edge 0; out_valid=1 from cycle 4 after acceptance.
- DONE: hold out_valid and result until out_ready=1. Next state IDLE, so in_ready=1 one cycle later. No back-to-back overlap; peak throughput is 1 operation per 5 cycles.
- Unpack (on accept):
  - exp==0 means zero; subnormals are flushed to zero.
  - Otherwise mantissa = {1, frac}, 11 bits.
  - exp==31 means inf or NaN.
  - Special-case flags are latched at accept; the FSM still walks all states, so latency is fixed.
- ALIGN:
  - Order by magnitude, {exp, frac} compare; larger is L, smaller is S.
  - d = eL - eS. S mantissa >> d; d >= 12 gives 0. Shifted-out bits are truncated.
  - Result sign = sign of L. Result exponent starts at eL.
- ADD:
  - Signs equal: sum = mL + mS.
  - Signs differ: sum = mL - mS.
  - Width is 12 bits, never negative.
- NORM: normalization detector on the 12-bit sum.
  - sum bit 11 set: mant = sum>>1, exp = eL+1.
  - Leading one at bit 10-k (k = 0..10): mant = sum<<k, exp = eL-k.
  - sum==0: result +0, 16'h0000.
  - Exponent arithmetic uses a signed 7-bit intermediate.
- Pack:
  - exp >= 31: ±inf, {s, 5'h1F, 10'h0}.
  - exp <= 0: ±0, flush; sign kept except exact cancellation, which gives +0.
  - Rounding is truncation only.
- Specials, which override the computed result:
  - Either input NaN: 16'h7E00.
  - inf + (-inf): 16'h7E00.
  - inf plus a finite value, or inf plus the same-sign inf: that inf.
  - Both inputs zero: sign = sA & sB.
  - One input zero: the other operand unchanged.
- in_valid while busy is ignored and not latched. a and b may change freely after acceptance.

Decomposition:
- Shared package fp16_pkg:
  - EXP_W, MAN_W, BIAS
  - constants QNAN=16'h7E00, PINF=16'h7C00
  - state enum {IDLE, ALIGN, ADD, NORM, DONE}
  - unpacked-operand struct {sign, exp[4:0], mant[10:0], is_zero, is_inf, is_nan}
- One sub-module: fp16_norm_detect.
  - Combinational priority encoder, 12-bit sum in.
  - Outputs dir (1 = right shift), shamt[3:0] and zero flag.
  - Instantiated once in NORM.

Test Plan:
- Basic: rst 2 cycles, then a=3C00, b=3C00 -> out_valid exactly 4 cycles after accept, result=4000; in_ready=0 and busy=1 throughout.
- Cancellation and left normalize: 3C00 + BC00 -> 0000. Then 4200 + C000 -> 3C00 (left shift 1).
- Alignment and truncation: 6400 + 3C00 -> 6401. 6400 + 3800 -> 6400 (d=11, truncated). 6400 + 0001 -> 6400 (subnormal flushed).
- Overflow and specials:
  - 7BFF + 7BFF -> 7C00.
  - 7C00 + 3C00 -> 7C00.
  - 7C00 + FC00 -> 7E00.
  - 7E01 + 0000 -> 7E00.
  - 8000 + 8000 -> 8000.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_valid and result stable, in_ready=0. A second in_valid pulse during busy is not accepted. Release out_ready -> in_ready=1 next cycle, and the next pair is accepted.
- Reset mid-operation: assert rst during ADD -> next cycle IDLE, out_valid=0, result=0000, in_ready=1; the aborted result never appears.
